aec_gen: RTL and testbench

- Parametrised next-generation arithmetic expression calculator. It takes one ASCII expression, one character per cycle, terminated by '='.
- It checks parenthesis legality, converts infix to postfix in an internal shunting-yard stage, evaluates the postfix form, and returns a modulo-2^DATA_W result with a one-cycle valid strobe.
- New versus the fixed-width predecessor:
  - configurable result width, buffer length and stack depth;
  - subtraction with wrap;
  - an error flag for bad characters, length overrun and stack overrun.

---
 rtl/aec_pkg.sv | 67 ++++++
 rtl/aec_lifo.sv | 59 +++++
 rtl/aec_gen.sv | 263 ++++++++++++++++++++++++++
 tb/tb_aec_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/aec_pkg.sv
// Shared ASCII codes, token types, FSM states and token helpers for the aec_gen calculator.
package aec_pkg;

    localparam logic [7:0] ChZero  = 8'h30;
    localparam logic [7:0] ChNine  = 8'h39;
    localparam logic [7:0] ChA     = 8'h61;
    localparam logic [7:0] ChF     = 8'h66;
    localparam logic [7:0] ChPlus  = 8'h2b;
    localparam logic [7:0] ChMinus = 8'h2d;
    localparam logic [7:0] ChStar  = 8'h2a;
    localparam logic [7:0] ChLpar  = 8'h28;
    localparam logic [7:0] ChRpar  = 8'h29;
    localparam logic [7:0] ChEq    = 8'h3d;

    typedef enum logic [2:0] {
        TokNum, TokAdd, TokSub, TokMul, TokLpar, TokRpar, TokEnd
    } tok_kind_e;

    typedef struct packed {
        tok_kind_e  kind;
        logic [3:0] val;
    } token_t;

    typedef struct packed {
        token_t tok;
        logic   illegal;
    } char_tok_t;

    typedef enum logic [2:0] {
        StIdle, StLoad, StConvert, StEval, StDone
    } state_e;

    function automatic logic [1:0] prec(input tok_kind_e k);
        logic [1:0] p;
        case (k)
            TokMul:         p = 2'd2;
            TokAdd, TokSub: p = 2'd1;
            default:        p = 2'd0;
        endcase
        return p;
    endfunction

    // Illegal characters map to a harmless zero operand; the flag alone carries the error.
    function automatic char_tok_t char2tok(input logic [7:0] c);
        char_tok_t r;
        r.tok.kind = TokNum;
        r.tok.val  = 4'd0;
        r.illegal  = 1'b0;
        if (c >= ChZero && c <= ChNine) begin
            r.tok.val = 4'(c - ChZero);
        end else if (c >= ChA && c <= ChF) begin
            r.tok.val = 4'(c - ChA + 8'd10);
        end else begin
            case (c)
                ChPlus:  r.tok.kind = TokAdd;
                ChMinus: r.tok.kind = TokSub;
                ChStar:  r.tok.kind = TokMul;
                ChLpar:  r.tok.kind = TokLpar;
                ChRpar:  r.tok.kind = TokRpar;
                ChEq:    r.tok.kind = TokEnd;
                default: r.illegal  = 1'b1;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/aec_lifo.sv
// LIFO with a second read port so a binary operator can fold the top two entries into one.
module aec_lifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             reduce_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic [WIDTH-1:0] next_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overrun_o
);
    localparam int unsigned     CntW   = $clog2(DEPTH + 1);
    localparam int unsigned     IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CntW-1:0]  cnt_q;
    logic [IdxW-1:0]  wr_idx, top_idx, nxt_idx;
    logic             has_two;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == DepthC);
    assign has_two   = (cnt_q > CntW'(1));
    assign wr_idx    = IdxW'(cnt_q);
    assign top_idx   = IdxW'(cnt_q - CntW'(1));
    assign nxt_idx   = IdxW'(cnt_q - CntW'(2));
    assign top_o     = empty_o ? '0 : mem_q[top_idx];
    assign next_o    = has_two ? mem_q[nxt_idx] : '0;
    // Underflow is reported alongside overflow: both mean the expression cannot be evaluated.
    assign overrun_o = (push_i && full_o) || (pop_i && empty_o) || (reduce_i && !has_two);

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
        end else if (push_i) begin
            if (!full_o) cnt_q <= cnt_q + CntW'(1);
        end else if (pop_i) begin
            if (!empty_o) cnt_q <= cnt_q - CntW'(1);
        end else if (reduce_i && has_two) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= data_i;
        end else if (reduce_i && has_two) begin
            mem_q[nxt_idx] <= data_i;
        end
    end

endmodule

// File: rtl/aec_gen.sv
// Expression calculator: buffers one '='-terminated ASCII expression, converts it to postfix
// with a shunting-yard pass and evaluates it modulo 2^DATA_W.
module aec_gen
    import aec_pkg::*;
#(
    parameter int unsigned DATA_W      = 7,
    parameter int unsigned MAX_LEN     = 32,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready,
    input  logic [7:0]        ascii_in,
    output logic              valid,
    output logic [DATA_W-1:0] result,
    output logic              parentheses_legal,
    output logic              error
);
    localparam int unsigned     LenW    = $clog2(MAX_LEN + 1);
    localparam int unsigned     IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned     DepW    = LenW + 1;
    localparam int unsigned     TokW    = $bits(token_t);
    localparam logic [LenW-1:0] MaxLenC = LenW'(MAX_LEN);

    state_e                 state_q;
    token_t                 cbuf_q [MAX_LEN];
    token_t                 pbuf_q [MAX_LEN];
    logic [LenW-1:0]        wr_cnt_q, rd_ptr_q, pf_cnt_q, ev_ptr_q;
    logic signed [DepW-1:0] depth_q, depth_base, depth_nxt;
    logic                   illegal_paren_q, err_q, ill_nxt, err_nxt;
    logic                   valid_q, legal_q, error_q;
    logic [DATA_W-1:0]      result_q;

    char_tok_t         in_ct;
    token_t            cur_tok, pf_tok, ops_din, ops_top, emit_tok;
    logic [TokW-1:0]   ops_top_raw, ops_next_unused;
    logic              ops_push, ops_pop, ops_empty, ops_ovr, ops_full_unused;
    logic              val_push, val_reduce, val_ovr, val_empty_unused, val_full_unused;
    logic [DATA_W-1:0] val_din, val_top, val_next, alu;
    logic              stack_clear, emit, rd_adv, conv_done;
    logic              finish, fin_err, fin_ill;

    assign in_ct       = char2tok(ascii_in);
    assign cur_tok     = cbuf_q[IdxW'(rd_ptr_q)];
    assign pf_tok      = pbuf_q[IdxW'(ev_ptr_q)];
    assign ops_top     = token_t'(ops_top_raw);
    assign stack_clear = (state_q == StIdle);

    aec_lifo #(.WIDTH(TokW), .DEPTH(STACK_DEPTH)) u_op_stack (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (stack_clear),
        .push_i    (ops_push),
        .pop_i     (ops_pop),
        .reduce_i  (1'b0),
        .data_i    (ops_din),
        .top_o     (ops_top_raw),
        .next_o    (ops_next_unused),
        .empty_o   (ops_empty),
        .full_o    (ops_full_unused),
        .overrun_o (ops_ovr)
    );

    aec_lifo #(.WIDTH(DATA_W), .DEPTH(STACK_DEPTH)) u_val_stack (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (stack_clear),
        .push_i    (val_push),
        .pop_i     (1'b0),
        .reduce_i  (val_reduce),
        .data_i    (val_din),
        .top_o     (val_top),
        .next_o    (val_next),
        .empty_o   (val_empty_unused),
        .full_o    (val_full_unused),
        .overrun_o (val_ovr)
    );

    // Paren bookkeeping for the incoming character; IDLE starts a fresh expression.
    always_comb begin
        depth_base = (state_q == StIdle) ? '0 : depth_q;
        ill_nxt    = (state_q == StIdle) ? 1'b0 : illegal_paren_q;
        err_nxt    = ((state_q == StIdle) ? 1'b0 : err_q) | in_ct.illegal;
        depth_nxt  = depth_base;
        case (in_ct.tok.kind)
            TokLpar: depth_nxt = depth_base + DepW'(1);
            TokRpar: begin
                depth_nxt = depth_base - DepW'(1);
                if (depth_base[DepW-1] || depth_base == '0) ill_nxt = 1'b1;
            end
            TokEnd:  if (depth_base != '0) ill_nxt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (pf_tok.kind)
            TokAdd:  alu = val_next + val_top;
            TokSub:  alu = val_next - val_top;
            default: alu = val_next * val_top;
        endcase
    end

    always_comb begin
        ops_push   = 1'b0;
        ops_pop    = 1'b0;
        ops_din    = cur_tok;
        emit       = 1'b0;
        emit_tok   = cur_tok;
        rd_adv     = 1'b0;
        conv_done  = 1'b0;
        val_push   = 1'b0;
        val_reduce = 1'b0;
        val_din    = DATA_W'(pf_tok.val);
        finish     = 1'b0;
        fin_err    = err_q;
        fin_ill    = illegal_paren_q;
        case (state_q)
            StLoad: begin
                if (wr_cnt_q == MaxLenC) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                    fin_ill = ill_nxt;
                end
            end
            StConvert: begin
                if (illegal_paren_q || err_q) begin
                    finish = 1'b1;
                end else begin
                    case (cur_tok.kind)
                        TokNum: begin
                            emit   = 1'b1;
                            rd_adv = 1'b1;
                        end
                        TokLpar: begin
                            ops_push = 1'b1;
                            rd_adv   = 1'b1;
                        end
                        TokRpar: begin
                            ops_pop = 1'b1;
                            if (ops_top.kind == TokLpar) begin
                                rd_adv = 1'b1;
                            end else begin
                                emit     = 1'b1;
                                emit_tok = ops_top;
                            end
                        end
                        TokEnd: begin
                            if (!ops_empty) begin
                                ops_pop  = 1'b1;
                                emit     = 1'b1;
                                emit_tok = ops_top;
                            end else begin
                                conv_done = 1'b1;
                            end
                        end
                        default: begin
                            // Stall the read pointer while stacked operators bind at least as tight.
                            if (!ops_empty && ops_top.kind != TokLpar &&
                                prec(ops_top.kind) >= prec(cur_tok.kind)) begin
                                ops_pop  = 1'b1;
                                emit     = 1'b1;
                                emit_tok = ops_top;
                            end else begin
                                ops_push = 1'b1;
                                rd_adv   = 1'b1;
                            end
                        end
                    endcase
                    if (ops_ovr) begin
                        finish  = 1'b1;
                        fin_err = 1'b1;
                    end
                end
            end
            StEval: begin
                if (ev_ptr_q == pf_cnt_q) begin
                    finish = 1'b1;
                end else begin
                    if (pf_tok.kind == TokNum) begin
                        val_push = 1'b1;
                    end else begin
                        val_reduce = 1'b1;
                        val_din    = alu;
                    end
                    if (val_ovr) begin
                        finish  = 1'b1;
                        fin_err = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            wr_cnt_q        <= '0;
            rd_ptr_q        <= '0;
            pf_cnt_q        <= '0;
            ev_ptr_q        <= '0;
            depth_q         <= '0;
            illegal_paren_q <= 1'b0;
            err_q           <= 1'b0;
            valid_q         <= 1'b0;
            legal_q         <= 1'b0;
            error_q         <= 1'b0;
            result_q        <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ready) begin
                        cbuf_q[IdxW'(0)] <= in_ct.tok;
                        wr_cnt_q         <= LenW'(1);
                        rd_ptr_q         <= '0;
                        pf_cnt_q         <= '0;
                        ev_ptr_q         <= '0;
                        depth_q          <= depth_nxt;
                        illegal_paren_q  <= ill_nxt;
                        err_q            <= err_nxt;
                        state_q          <= (in_ct.tok.kind == TokEnd) ? StConvert : StLoad;
                    end
                end
                StLoad: begin
                    if (!finish) begin
                        cbuf_q[IdxW'(wr_cnt_q)] <= in_ct.tok;
                        wr_cnt_q                <= wr_cnt_q + LenW'(1);
                        depth_q                 <= depth_nxt;
                        illegal_paren_q         <= ill_nxt;
                        err_q                   <= err_nxt;
                        if (in_ct.tok.kind == TokEnd) state_q <= StConvert;
                    end
                end
                StConvert: begin
                    if (emit) begin
                        pbuf_q[IdxW'(pf_cnt_q)] <= emit_tok;
                        pf_cnt_q                <= pf_cnt_q + LenW'(1);
                    end
                    if (rd_adv) rd_ptr_q <= rd_ptr_q + LenW'(1);
                    if (conv_done) state_q <= StEval;
                end
                StEval:  ev_ptr_q <= ev_ptr_q + LenW'(1);
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (finish) begin
                state_q  <= StDone;
                valid_q  <= 1'b1;
                error_q  <= fin_err;
                legal_q  <= ~fin_ill;
                result_q <= (fin_err || fin_ill) ? '0 : val_top;
            end
        end
    end

    assign valid             = valid_q;
    assign result            = result_q;
    assign parentheses_legal = legal_q;
    assign error             = error_q;

endmodule

// File: tb/tb_aec_gen.sv
// Directed bench for aec_gen: a default instance plus a 12-bit, 8-character, 2-deep instance.
module tb_aec_gen;

    localparam int WaitMax = 3 * 32 + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready_a = 1'b0;
    logic        ready_b = 1'b0;
    logic [7:0]  ascii_in = 8'h00;
    logic        valid_a, legal_a, error_a;
    logic [6:0]  result_a;
    logic        valid_b, legal_b, error_b;
    logic [11:0] result_b;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;
    int vcount;

    always #5 clk = ~clk;

    aec_gen u_dut_a (
        .clk               (clk),
        .rst               (rst),
        .ready             (ready_a),
        .ascii_in          (ascii_in),
        .valid             (valid_a),
        .result            (result_a),
        .parentheses_legal (legal_a),
        .error             (error_a)
    );

    aec_gen #(.DATA_W(12), .MAX_LEN(8), .STACK_DEPTH(2)) u_dut_b (
        .clk               (clk),
        .rst               (rst),
        .ready             (ready_b),
        .ascii_in          (ascii_in),
        .valid             (valid_b),
        .result            (result_b),
        .parentheses_legal (legal_b),
        .error             (error_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // who: 0 = instance A, 1 = instance B, 2 = no ready pulse at all.
    task automatic send_expr(input string s, input int who);
        for (int i = 0; i < s.len(); i++) begin
            ascii_in = s[i];
            if (i == 0 && who == 0) ready_a = 1'b1;
            if (i == 0 && who == 1) ready_b = 1'b1;
            @(posedge clk);
            #1;
            ready_a = 1'b0;
            ready_b = 1'b0;
        end
        ascii_in = 8'h00;
    endtask

    task automatic wait_valid(input bit on_b, output int cycles);
        int k;
        k      = 0;
        cycles = 0;
        while (cycles == 0 && k < WaitMax) begin
            k++;
            @(posedge clk);
            #1;
            if ((on_b ? valid_b : valid_a) === 1'b1) cycles = k;
        end
    endtask

    task automatic expect_done(input string tag, input bit on_b, input logic [31:0] res,
                               input logic legal, input logic err);
        wait_valid(on_b, lat);
        check({tag, ".valid_seen"}, 32'(lat != 0), 32'd1);
        check({tag, ".result"}, on_b ? 32'(result_b) : 32'(result_a), res);
        check({tag, ".legal"}, on_b ? 32'(legal_b) : 32'(legal_a), 32'(legal));
        check({tag, ".error"}, on_b ? 32'(error_b) : 32'(error_a), 32'(err));
    endtask

    task automatic after_done(input string tag, input bit on_b, input logic [31:0] res);
        @(posedge clk);
        #1;
        ready_a  = 1'b0;
        ready_b  = 1'b0;
        ascii_in = 8'h00;
        check({tag, ".valid_fall"}, on_b ? 32'(valid_b) : 32'(valid_a), 32'd0);
        check({tag, ".hold"}, on_b ? 32'(result_b) : 32'(result_a), res);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset.valid", 32'(valid_a), 32'd0);
        check("reset.result", 32'(result_a), 32'd0);
        check("reset.legal", 32'(legal_a), 32'd0);
        check("reset.error", 32'(error_a), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send_expr("2*(3+4)=", 0);
        expect_done("paren_mul", 0, 14, 1'b1, 1'b0);
        after_done("paren_mul", 0, 14);

        send_expr("9-3-2=", 0);
        expect_done("left_assoc", 0, 4, 1'b1, 1'b0);
        // A ready coincident with valid must be ignored; '(' would poison the next expression.
        ready_a  = 1'b1;
        ascii_in = "(";
        after_done("left_assoc", 0, 4);
        send_expr("a-b=", 0);
        expect_done("wrap_sub", 0, 127, 1'b1, 1'b0);
        after_done("wrap_sub", 0, 127);

        send_expr("f*f*f=", 0);
        expect_done("mul7", 0, 47, 1'b1, 1'b0);
        after_done("mul7", 0, 47);
        send_expr("f*f*f=", 1);
        expect_done("mul12", 1, 3375, 1'b1, 1'b0);
        after_done("mul12", 1, 3375);

        send_expr("1+2*3=", 0);
        expect_done("prec", 0, 7, 1'b1, 1'b0);
        after_done("prec", 0, 7);
        send_expr("2*3-4*5=", 0);
        expect_done("prec_wrap", 0, 114, 1'b1, 1'b0);
        after_done("prec_wrap", 0, 114);
        send_expr("(7-2)*(1+c)=", 0);
        expect_done("hex_paren", 0, 65, 1'b1, 1'b0);
        after_done("hex_paren", 0, 65);
        send_expr("3*(2+(4-1))*2=", 0);
        expect_done("nested", 0, 30, 1'b1, 1'b0);
        after_done("nested", 0, 30);
        send_expr("e+d=", 0);
        expect_done("hex_add", 0, 27, 1'b1, 1'b0);
        after_done("hex_add", 0, 27);

        send_expr("(1+2))=", 0);
        expect_done("extra_close", 0, 0, 1'b0, 1'b0);
        after_done("extra_close", 0, 0);
        send_expr("((1+2)=", 0);
        expect_done("unclosed", 0, 0, 1'b0, 1'b0);
        after_done("unclosed", 0, 0);
        send_expr(")1(=", 0);
        expect_done("close_first", 0, 0, 1'b0, 1'b0);
        check("close_first.latency", 32'(lat), 32'd1);
        after_done("close_first", 0, 0);

        send_expr("1+x=", 0);
        expect_done("bad_char", 0, 0, 1'b1, 1'b1);
        check("bad_char.latency", 32'(lat), 32'd1);
        after_done("bad_char", 0, 0);

        send_expr("1+2+3+4=", 1);
        expect_done("len_exact", 1, 10, 1'b1, 1'b0);
        after_done("len_exact", 1, 10);
        send_expr("1+1+1+1+1", 1);
        check("len_over.valid", 32'(valid_b), 32'd1);
        check("len_over.error", 32'(error_b), 32'd1);
        check("len_over.result", 32'(result_b), 32'd0);
        after_done("len_over", 1, 0);
        send_expr("(((1)))=", 1);
        expect_done("op_overrun", 1, 0, 1'b1, 1'b1);
        after_done("op_overrun", 1, 0);

        send_expr("1+2", 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst.legal", 32'(legal_a), 32'd0);
        check("mid_rst.result", 32'(result_a), 32'd0);
        send_expr("+3=", 2);
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (valid_a === 1'b1) vcount++;
        end
        check("mid_rst.no_valid", 32'(vcount), 32'd0);
        send_expr("5*5=", 0);
        expect_done("post_rst", 0, 25, 1'b1, 1'b0);
        after_done("post_rst", 0, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
